// File: rtl/tdm_demultiplexer.sv
// TDM line receiver: locks a 2-bit slot counter to frame sync and delivers 4-slot frames on out0..out3.
// Latency 1 cycle from the slot-3 beat to out*/frame_valid; no backpressure, enable=0 freezes all state.
module tdm_demultiplexer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             address0,
    output logic             address1,
    output logic             frame_valid,
    output logic             sync_error,
    output logic             locked
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] stage0_q, stage0_d;
    logic [WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0] stage2_q, stage2_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_error_q, sync_error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= UNLOCKED;
            slot_q        <= 2'd0;
            stage0_q      <= '0;
            stage1_q      <= '0;
            stage2_q      <= '0;
            out0_q        <= '0;
            out1_q        <= '0;
            out2_q        <= '0;
            out3_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            stage0_q      <= stage0_d;
            stage1_q      <= stage1_d;
            stage2_q      <= stage2_d;
            out0_q        <= out0_d;
            out1_q        <= out1_d;
            out2_q        <= out2_d;
            out3_q        <= out3_d;
            frame_valid_q <= frame_valid_d;
            sync_error_q  <= sync_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        stage0_d      = stage0_q;
        stage1_d      = stage1_q;
        stage2_d      = stage2_q;
        out0_d        = out0_q;
        out1_d        = out1_q;
        out2_d        = out2_q;
        out3_d        = out3_q;
        frame_valid_d = 1'b0;
        sync_error_d  = 1'b0;

        if (enable) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (sync) begin
                        stage0_d = in;
                        slot_d   = 2'd1;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync beat always starts a new frame; mid-frame it also flags the torn frame.
                        sync_error_d = (slot_q != 2'd0);
                        stage0_d     = in;
                        slot_d       = 2'd1;
                    end else begin
                        unique case (slot_q)
                            2'd0: begin
                                sync_error_d = 1'b1;
                                state_d      = UNLOCKED;
                                slot_d       = 2'd0;
                            end
                            2'd1: begin
                                stage1_d = in;
                                slot_d   = 2'd2;
                            end
                            2'd2: begin
                                stage2_d = in;
                                slot_d   = 2'd3;
                            end
                            2'd3: begin
                                out0_d        = stage0_q;
                                out1_d        = stage1_q;
                                out2_d        = stage2_q;
                                out3_d        = in;
                                frame_valid_d = 1'b1;
                                slot_d        = 2'd0;
                            end
                            default: slot_d = 2'd0;
                        endcase
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign address0    = slot_q[0];
    assign address1    = slot_q[1];
    assign frame_valid = frame_valid_q;
    assign sync_error  = sync_error_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: directed scenarios plus random beats, checked every cycle against a frame-level model.
module tb_tdm_demultiplexer;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         sync;
    logic [W-1:0] in_b;
    logic [W-1:0] out0, out1, out2, out3;
    logic         address0, address1;
    logic         frame_valid, sync_error, locked;

    int errors = 0;
    int checks = 0;

    // Reference model: the frame in progress is a queue whose length is the slot index.
    logic [W-1:0] m_frame[$];
    logic [W-1:0] m_out[4];
    bit           m_locked = 0;
    bit           m_fv = 0;
    bit           m_se = 0;

    tdm_demultiplexer #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sync(sync),
        .in(in_b),
        .out0(out0),
        .out1(out1),
        .out2(out2),
        .out3(out3),
        .address0(address0),
        .address1(address1),
        .frame_valid(frame_valid),
        .sync_error(sync_error),
        .locked(locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model(input bit rst, input bit en, input bit sy, input logic [W-1:0] d);
        m_fv = 0;
        m_se = 0;
        if (rst) begin
            m_frame.delete();
            m_locked = 0;
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else if (en) begin
            if (!m_locked) begin
                if (sy) begin
                    m_frame.delete();
                    m_frame.push_back(d);
                    m_locked = 1;
                end
            end else if (sy) begin
                m_se = (m_frame.size() != 0);
                m_frame.delete();
                m_frame.push_back(d);
            end else if (m_frame.size() == 0) begin
                m_se = 1;
                m_locked = 0;
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                    m_fv = 1;
                    m_frame.delete();
                end
            end
        end
    endfunction

    task automatic check_all();
        int n;
        logic [1:0] a;
        n = m_frame.size();
        a = 2'(n);
        chk("outs", 32'({out3, out2, out1, out0}), 32'({m_out[3], m_out[2], m_out[1], m_out[0]}));
        chk("addr", 32'({address1, address0}), 32'(a));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("sync_error", 32'(sync_error), 32'(m_se));
        chk("locked", 32'(locked), 32'(m_locked));
    endtask

    task automatic step(input bit rst, input bit en, input bit sy, input logic [W-1:0] d);
        reset  = rst;
        enable = en;
        sync   = sy;
        in_b   = d;
        @(posedge clk);
        model(rst, en, sy, d);
        #1;
        check_all();
    endtask

    task automatic beat(input bit sy, input logic [W-1:0] d);
        step(1'b0, 1'b1, sy, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, W'($urandom));
    endtask

    initial begin
        int pulses;
        reset  = 1'b1;
        enable = 1'b0;
        sync   = 1'b0;
        in_b   = '0;

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 4'hF);
        idle(10);

        // Single frame with 1-bit-style data
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h1);
        beat(1'b0, 4'h1);
        chk("single_frame_out", 32'({out3, out2, out1, out0}), 32'h1101);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("single_frame_pulse_len", 32'(frame_valid), 32'd0);

        // Gapped frame A followed directly by frame B
        pulses = 0;
        beat(1'b1, 4'h1); pulses += int'(frame_valid);
        beat(1'b0, 4'h2); pulses += int'(frame_valid);
        idle(2);
        beat(1'b0, 4'h3); pulses += int'(frame_valid);
        beat(1'b0, 4'h4); pulses += int'(frame_valid);
        chk("frame_a", 32'({out3, out2, out1, out0}), 32'h4321);
        beat(1'b1, 4'hA); pulses += int'(frame_valid);
        beat(1'b0, 4'hB); pulses += int'(frame_valid);
        beat(1'b0, 4'hC); pulses += int'(frame_valid);
        beat(1'b0, 4'hD); pulses += int'(frame_valid);
        chk("frame_b", 32'({out3, out2, out1, out0}), 32'hDCBA);
        chk("gapped_pulse_count", 32'(pulses), 32'd2);

        // Early sync at slot 2
        beat(1'b1, 4'h5);
        beat(1'b0, 4'h6);
        beat(1'b1, 4'h7);
        chk("early_sync_err", 32'(sync_error), 32'd1);
        chk("early_sync_hold", 32'({out3, out2, out1, out0}), 32'hDCBA);
        beat(1'b0, 4'h8);
        beat(1'b0, 4'h9);
        beat(1'b0, 4'hE);
        chk("resync_frame", 32'({out3, out2, out1, out0}), 32'hE987);

        // Missing sync at slot 0, then non-sync beats ignored until relock
        beat(1'b0, 4'h3);
        chk("missing_sync_lock", 32'(locked), 32'd0);
        beat(1'b0, 4'h4);
        beat(1'b0, 4'h5);
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h2);
        idle(3);
        beat(1'b0, 4'h3);
        beat(1'b0, 4'h4);
        chk("relock_frame", 32'({out3, out2, out1, out0}), 32'h4321);

        // Reset mid-frame at slot 2
        beat(1'b1, 4'hA);
        beat(1'b0, 4'hB);
        step(1'b1, 1'b1, 1'b0, 4'hC);
        chk("mid_reset_outs", 32'({out3, out2, out1, out0}), 32'h0);
        beat(1'b1, 4'h6);
        beat(1'b0, 4'h7);
        beat(1'b0, 4'h8);
        beat(1'b0, 4'h9);
        chk("post_reset_frame", 32'({out3, out2, out1, out0}), 32'h9876);

        // Random traffic: mostly well-formed frames with gaps, stray syncs, missing syncs, resets
        for (int i = 0; i < 3000; i++) begin
            bit en, sy, rst;
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if (m_frame.size() == 0)
                sy = ($urandom_range(0, 9) != 0);
            else
                sy = ($urandom_range(0, 19) == 0);
            step(rst, en, sy, W'($urandom));
            if (frame_valid && sync_error)
                chk("fv_se_exclusive", 32'({frame_valid, sync_error}), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demultiplexer.md
# tdm_demultiplexer

Receive-side counterpart of the team's 4:1 multiplexer for time-division links. It accepts one slot per enabled cycle from a shared line and tracks the slot address with an internal 2-bit counter locked to a frame-sync marker. Each completed frame is delivered to four registered outputs, out0..out3, updated together. Slot k maps to outk, using the same address convention as the multiplexer: address = {address1, address0}.

## Interface
Parameters:
- WIDTH, default 1, bit width of one slot / each output

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  line beat valid this cycle; all state holds when low
- sync  input  1  qualifies the current beat as slot 0 of a frame (sampled only with enable)
- in  input  WIDTH  line data for the current beat
- out0, out1, out2, out3  output  WIDTH  registered slot data of the last complete frame
- address0, address1  output  1  slot index the next enabled beat is stored into
- frame_valid  output  1  one-cycle pulse: out0..out3 just updated
- sync_error  output  1  one-cycle pulse: sync protocol violation
- locked  output  1  high while aligned to frame boundaries

## Operation
- Storage: staging registers stage0..stage2 (WIDTH each), 2-bit slot counter, and a state bit with states UNLOCKED and LOCKED.
- Reset state: UNLOCKED, slot 0, stage* = 0, out0..out3 = 0, frame_valid = 0, sync_error = 0, locked = 0.
- enable = 0: no state change; frame_valid and sync_error are 0 the next cycle.
- UNLOCKED:
  - Beats without sync are discarded.
  - On enable & sync: stage0 <= in, slot <= 1, go to LOCKED.
- LOCKED, enable = 1, normal beats:
  - Slot 0 with sync: stage0 <= in, slot <= 1.
  - Slot 1 or 2 without sync: stage[slot] <= in, slot increments.
  - Slot 3 without sync: out0 <= stage0, out1 <= stage1, out2 <= stage2, out3 <= in (all in the same edge); frame_valid = 1 next cycle; slot wraps to 0.
- LOCKED, enable = 1, violations:
  - sync at slot 1..3: sync_error = 1 next cycle. The partial frame is discarded and out* is unchanged. The beat is taken as slot 0 (stage0 <= in, slot <= 1). Remain LOCKED.
  - No sync at slot 0: sync_error = 1 next cycle. The beat is discarded, the block returns to UNLOCKED, and slot <= 0.
- Only the stage registers and outputs are WIDTH bits wide; no arithmetic is performed on data. The counter wraps 3 -> 0 modulo 4.
- locked reflects the state register: 1 exactly while in LOCKED.
- {address1, address0} always equals the slot counter, so a local 4:1 multiplexer driven by these outputs selects the matching source.

## Timing
- All outputs are registered and change only on rising clk.
- Latency: the slot-3 beat sampled at edge N produces out0..out3 and frame_valid = 1 during cycle N+1.
- out0..out3 hold their value until the next complete frame or reset.
- Throughput: back-to-back frames with no bubbles, one frame per 4 enabled beats. Any number of enable = 0 gaps is allowed inside or between frames.
- frame_valid and sync_error never assert in the same cycle.
- frame_valid is never asserted for two consecutive cycles unless frames arrive faster than every 4 cycles, which is impossible; at most one pulse occurs per 4 enabled beats.
- Reset has priority over every other input in the same cycle, including mid-frame:
  - The partial frame is discarded.
  - All outputs read 0 in the cycle after the reset edge.
  - No frame_valid or sync_error pulse results.

## Test plan
- Reset and idle: hold reset for 2 cycles, then enable = 0 for 10 cycles -> out0..out3 = 0, address = 00, locked, frame_valid and sync_error stay 0.
- Single frame, WIDTH = 1: enable = 1; in = 1 with sync, then in = 0, 1, 1 -> one cycle after the 4th edge, out0..out3 = 1, 0, 1, 1 and frame_valid is high for exactly 1 cycle; locked = 1 from the cycle after the first beat.
- Gapped back-to-back frames, WIDTH = 4:
  - Frame A = 0x1, 0x2, 0x3, 0x4 with enable low for 2 cycles after slot 1; frame B = 0xA, 0xB, 0xC, 0xD follows immediately.
  - Required: out* updates to 1, 2, 3, 4, then to A, B, C, D; exactly 2 frame_valid pulses; address sequence 00 01 10 11 00.
- Early sync: after a good frame, send 2 beats, then a sync beat at slot 2, then 3 more beats -> sync_error pulse, out* unchanged, no frame_valid until the resynchronised frame completes with the new data.
- Missing sync: after lock, send a slot-0 beat without sync -> sync_error pulse, locked = 0, and following non-sync beats are ignored until a sync beat restores lock.
- Reset mid-frame: assert reset at slot 2 -> next cycle all outputs are 0, locked = 0, no pulse; a fresh frame afterwards decodes correctly.
